// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port (fetch / load-store) arbiter onto one SRAM-like bus.
// One transaction is outstanding at a time: IDLE grants, ADDR issues the
// request, and WAIT waits for the data phase.
// Optional build macro ARB_RR_EN switches the fixed data-over-inst priority to a
// round-robin that uses a 1-bit last-owner pointer.
module sram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        owner_data_r;   // 1: load/store port owns the bus, 0: fetch port
  logic        wr_r;
  logic [3:0]  wstrb_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        data_first_s;
  logic        grant_data_s;
  logic        grant_inst_s;
  logic        issuing_s;
  logic        busy_s;

`ifdef ARB_RR_EN
  logic        last_data_r;    // 1: most recent grant went to the load/store port

  // Round-robin: the port that was not granted last wins a tie.
  always_comb begin
    data_first_s = ~last_data_r;
  end
`else
  // Fixed priority: the load/store port always wins a tie.
  always_comb begin
    data_first_s = 1'b1;
  end
`endif

  // Grant decision; only in IDLE and never while reset is asserted, so that
  // addr_ok stays low during reset even if a request is already present.
  always_comb begin
    grant_data_s = 1'b0;
    grant_inst_s = 1'b0;
    if ((state_r == ST_IDLE) && rst) begin
      if (data_req && (!inst_req || data_first_s)) begin
        grant_data_s = 1'b1;
      end else if (inst_req) begin
        grant_inst_s = 1'b1;
      end else begin
        grant_data_s = 1'b0;
        grant_inst_s = 1'b0;
      end
    end else begin
      grant_data_s = 1'b0;
      grant_inst_s = 1'b0;
    end
  end

  // Next-state logic; bus_data_ok ends the transaction from ADDR or WAIT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_data_s || grant_inst_s) begin
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (bus_data_ok) begin
          state_nxt_s = ST_IDLE;
        end else if (bus_addr_ok) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_WAIT: begin
        if (bus_data_ok) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the winner's request fields; fetches are always plain reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_data_r <= 1'b0;
      wr_r         <= 1'b0;
      wstrb_r      <= 4'b0000;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
    end else if (grant_data_s) begin
      owner_data_r <= 1'b1;
      wr_r         <= data_wr;
      wstrb_r      <= data_wstrb;
      addr_r       <= data_addr;
      wdata_r      <= data_wdata;
    end else if (grant_inst_s) begin
      owner_data_r <= 1'b0;
      wr_r         <= 1'b0;
      wstrb_r      <= 4'b0000;
      addr_r       <= inst_addr;
      wdata_r      <= 32'h0000_0000;
    end
  end

`ifdef ARB_RR_EN
  // Remember which port received the most recent grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_data_r <= 1'b0;
    end else if (grant_data_s || grant_inst_s) begin
      last_data_r <= grant_data_s;
    end
  end
`endif

  // Bus drive and requester responses; bus fields are zero outside ADDR.
  always_comb begin
    issuing_s    = (state_r == ST_ADDR);
    busy_s       = (state_r == ST_ADDR) || (state_r == ST_WAIT);
    bus_req      = issuing_s;
    bus_wr       = issuing_s & wr_r;
    bus_wstrb    = issuing_s ? wstrb_r : 4'b0000;
    bus_addr     = issuing_s ? addr_r  : 32'h0000_0000;
    bus_wdata    = issuing_s ? wdata_r : 32'h0000_0000;
    inst_addr_ok = grant_inst_s;
    data_addr_ok = grant_data_s;
    inst_data_ok = busy_s & bus_data_ok & ~owner_data_r;
    data_data_ok = busy_s & bus_data_ok &  owner_data_r;
    inst_rdata   = bus_rdata;
    data_rdata   = bus_rdata;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by a
// randomized phase, all checked against a transaction-level reference model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one pending transaction record plus the last owner.
  bit          m_busy, m_addr_done, m_owner_data, m_last_data;
  logic        m_wr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  bit          e_gd, e_gi;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_addr_done = 1'b0; m_owner_data = 1'b0; m_last_data = 1'b0;
    m_wr = 1'b0; m_wstrb = 4'b0000; m_addr = 32'h0; m_wdata = 32'h0;
  endtask

  // Settle after the falling edge, predict every output, compare.
  task automatic check_outputs();
    bit prefer_data;
    bit issuing;
    #1;
`ifdef ARB_RR_EN
    prefer_data = !m_last_data;
`else
    prefer_data = 1'b1;
`endif
    e_gd = rst && !m_busy && data_req && (!inst_req || prefer_data);
    e_gi = rst && !m_busy && inst_req && !e_gd;
    issuing = m_busy && !m_addr_done;
    chk1("inst_addr_ok", inst_addr_ok, e_gi);
    chk1("data_addr_ok", data_addr_ok, e_gd);
    chk1("inst_data_ok", inst_data_ok, m_busy && bus_data_ok && !m_owner_data);
    chk1("data_data_ok", data_data_ok, m_busy && bus_data_ok && m_owner_data);
    chk1("bus_req", bus_req, issuing);
    chk1("bus_wr", bus_wr, issuing ? m_wr : 1'b0);
    chk32("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, issuing ? m_wstrb : 4'b0000});
    chk32("bus_addr", bus_addr, issuing ? m_addr : 32'h0);
    chk32("bus_wdata", bus_wdata, issuing ? m_wdata : 32'h0);
    chk32("inst_rdata", inst_rdata, bus_rdata);
    chk32("data_rdata", data_rdata, bus_rdata);
  endtask

  // Clock edge: advance the model with the inputs that were just checked.
  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (e_gd || e_gi) begin
      m_busy = 1'b1; m_addr_done = 1'b0;
      m_owner_data = e_gd; m_last_data = e_gd;
      m_wr    = e_gd ? data_wr    : 1'b0;
      m_wstrb = e_gd ? data_wstrb : 4'b0000;
      m_addr  = e_gd ? data_addr  : inst_addr;
      m_wdata = e_gd ? data_wdata : 32'h0;
    end else if (m_busy) begin
      if (bus_data_ok) m_busy = 1'b0;
      else if (bus_addr_ok) m_addr_done = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic step();
    check_outputs();
    advance();
  endtask

  initial begin
    bit hold_i, hold_d, first_data;

    rst = 1'b0;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'b0000; data_addr = 32'h0; data_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    model_reset();
    @(negedge clk);
    step();
    step();
    rst = 1'b1;
    step();

    // Single load: grant at 0, bus_addr_ok at 2, bus_data_ok at 4.
    data_req = 1'b1; data_addr = 32'h0000_1000;
    check_outputs();
    chk1("load_grant", data_addr_ok, 1'b1);
    advance();
    data_req = 1'b0;
    step();
    bus_addr_ok = 1'b1; step();
    bus_addr_ok = 1'b0; step();
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    check_outputs();
    chk1("load_data_ok", data_data_ok, 1'b1);
    chk32("load_rdata", data_rdata, 32'hDEAD_BEEF);
    chk1("load_inst_silent", inst_data_ok, 1'b0);
    advance();
    bus_data_ok = 1'b0; bus_rdata = 32'h0;
    step();

    // Store held through three stalled address cycles.
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_wdata = 32'h1234_5678; data_addr = 32'h0000_2004;
    step();
    data_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_outputs();
      chk32("store_wstrb", {28'h0, bus_wstrb}, 32'h0000_0003);
      chk1("store_wr", bus_wr, 1'b1);
      advance();
    end
    bus_addr_ok = 1'b1; step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    check_outputs();
    chk1("store_data_ok", data_data_ok, 1'b1);
    advance();
    bus_data_ok = 1'b0; data_wr = 1'b0; data_wstrb = 4'b0000;

    // Same-cycle acknowledge on a fetch, then immediate regrant (no WAIT).
    inst_req = 1'b1; inst_addr = 32'h0000_0040;
    step();
    inst_req = 1'b0;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
    check_outputs();
    chk1("same_cycle_data_ok", inst_data_ok, 1'b1);
    advance();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    inst_req = 1'b1; inst_addr = 32'h0000_0044;
    check_outputs();
    chk1("same_cycle_back_idle", inst_addr_ok, 1'b1);
    advance();
    inst_req = 1'b0;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

    // Contention after a data transaction (last owner = data).
    data_req = 1'b1; data_addr = 32'h0000_3000; step();
    data_req = 1'b0; bus_data_ok = 1'b1; step();
    bus_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0080;
    data_req = 1'b1; data_addr = 32'h0000_3008;
`ifdef ARB_RR_EN
    first_data = 1'b0;
`else
    first_data = 1'b1;
`endif
    check_outputs();
    chk1("contend_first_data", data_addr_ok, first_data);
    chk1("contend_first_inst", inst_addr_ok, !first_data);
    advance();
    if (first_data) data_req = 1'b0; else inst_req = 1'b0;
    step();
    bus_data_ok = 1'b1; step();
    bus_data_ok = 1'b0;
    check_outputs();
    chk1("contend_second_data", data_addr_ok, !first_data);
    chk1("contend_second_inst", inst_addr_ok, first_data);
    advance();
    inst_req = 1'b0; data_req = 1'b0;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

    // Reset while in WAIT; the late bus_data_ok must be ignored.
    data_req = 1'b1; data_addr = 32'h0000_4000; step();
    data_req = 1'b0; bus_addr_ok = 1'b1; step();
    bus_addr_ok = 1'b0; step();
    rst = 1'b0;
    model_reset();
    check_outputs();
    chk1("rst_bus_req", bus_req, 1'b0);
    advance();
    rst = 1'b1; bus_data_ok = 1'b1;
    check_outputs();
    chk1("rst_no_data_ok", data_data_ok, 1'b0);
    advance();
    bus_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_00C0;
    check_outputs();
    chk1("rst_then_grant", inst_addr_ok, 1'b1);
    advance();
    inst_req = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

    // Spurious bus_data_ok in IDLE.
    bus_data_ok = 1'b1;
    check_outputs();
    chk1("spurious_inst", inst_data_ok, 1'b0);
    chk1("spurious_data", data_data_ok, 1'b0);
    advance();
    bus_data_ok = 1'b0;
    step();

    // Randomized traffic with held requests, occasional withdrawal, random acks.
    hold_i = 1'b0; hold_d = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold_i && $urandom_range(3) == 0) begin
        hold_i = 1'b1; inst_addr = $urandom;
      end else if (hold_i && $urandom_range(15) == 0) begin
        hold_i = 1'b0;
      end
      if (!hold_d && $urandom_range(3) == 0) begin
        hold_d = 1'b1; data_wr = 1'($urandom_range(1));
        data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end else if (hold_d && $urandom_range(15) == 0) begin
        hold_d = 1'b0;
      end
      inst_req = hold_i; data_req = hold_d;
      bus_addr_ok = 1'($urandom_range(1));
      bus_data_ok = ($urandom_range(2) == 0);
      bus_rdata = $urandom;
      check_outputs();
      if (e_gi) hold_i = 1'b0;
      if (e_gd) hold_d = 1'b0;
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
